// File: rtl/iob_wb_burst_mem_slave.sv
// iob_wb_burst_mem_slave
//   Wishbone B3 responder backed by an internal 32-bit word memory. It answers classic
//   and incrementing-burst (linear / wrap4 / wrap8 / wrap16) cycles. A programmable
//   number of wait states precedes the first termination of every cycle. Later burst
//   beats are back-to-back. Beats outside the mapped window are answered with err.
//
// Ports
//   wb_clk_i, wb_rst_n_i    clock, synchronous active-low reset
//   wb_adr_i                byte address (bits [1:0] ignored)
//   wb_dat_i / wb_dat_o     write data / read data (valid while ack is high)
//   wb_sel_i                byte-lane enables for writes
//   wb_we_i                 1 = write, 0 = read (sampled per beat)
//   wb_cyc_i, wb_stb_i      bus cycle / strobe
//   wb_cti_i, wb_bte_i      cycle type / burst type
//   wb_ack_o, wb_err_o      registered single-cycle terminations
//   stall_i                 backpressure: no new termination is issued while high

module iob_wb_burst_mem_slave #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       MEM_ADDR_W  = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int unsigned       WAIT_STATES = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   input  logic              stall_i
);

   localparam int unsigned MemDepth = 2 ** MEM_ADDR_W;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StClassicResp,
      StBurst
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   // Byte offset from BASE_ADDR. Addresses below the base wrap around to huge offsets,
   // so a single upper-bits test covers both ends of the window.
   logic [ADDR_W-1:0]   off_q, off_d;
   logic                burst_q, burst_d;
   logic [1:0]          bte_q, bte_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   dat_q, dat_d;

   logic [DATA_W-1:0]   mem_q [MemDepth];

   logic [ADDR_W-1:0]   off_inc;
   logic [ADDR_W-1:0]   wrap_mask;
   logic [ADDR_W-1:0]   off_next;
   logic                term;
   logic [ADDR_W-1:0]   term_off;
   logic                mem_we;

   function automatic logic in_range(input logic [ADDR_W-1:0] off);
      return (off >> (MEM_ADDR_W + 2)) == '0;
   endfunction

   // Next burst address: only the bits selected by the wrap mask take the increment.
   always_comb begin
      off_inc   = off_q + ADDR_W'(4);
      wrap_mask = '1;
      unique case (bte_q)
         2'b00: wrap_mask = '1;
         2'b01: wrap_mask = ADDR_W'(12);
         2'b10: wrap_mask = ADDR_W'(28);
         2'b11: wrap_mask = ADDR_W'(60);
      endcase
      off_next = (off_q & ~wrap_mask) | (off_inc & wrap_mask);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      off_d    = off_q;
      burst_d  = burst_q;
      bte_d    = bte_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = dat_q;
      term     = 1'b0;
      term_off = off_q;

      unique case (state_q)
         StIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_STATES);
               off_d   = (wb_adr_i - BASE_ADDR) & ~ADDR_W'(3);
               burst_d = (wb_cti_i == 3'b010);
               bte_d   = wb_bte_i;
            end
         end
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!stall_i) begin
               term    = 1'b1;
               state_d = burst_q ? StBurst : StClassicResp;
            end
         end
         StClassicResp: begin
            state_d = StIdle;
         end
         StBurst: begin
            if (err_q) begin
               state_d = StIdle;
            end else if (ack_q) begin
               // The acked beat completes at this edge; the following beat is answered
               // from the already advanced address so reads stream without a bubble.
               off_d = off_next;
               if (wb_cti_i == 3'b111) begin
                  state_d = StIdle;
               end else if (wb_stb_i && !stall_i) begin
                  term     = 1'b1;
                  term_off = off_next;
               end
            end else if (wb_stb_i && !stall_i) begin
               term = 1'b1;
            end
         end
      endcase

      if (!wb_cyc_i) begin
         state_d = StIdle;
         term    = 1'b0;
      end

      if (term) begin
         if (in_range(term_off)) begin
            ack_d = 1'b1;
            dat_d = mem_q[term_off[MEM_ADDR_W+1:2]];
         end else begin
            err_d = 1'b1;
            dat_d = '0;
         end
      end
   end

   // Write data is taken during the ack cycle, at the edge that completes the beat.
   always_comb begin
      mem_we = ack_q && wb_cyc_i && wb_stb_i && wb_we_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         off_q   <= '0;
         burst_q <= 1'b0;
         bte_q   <= 2'b00;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         burst_q <= burst_d;
         bte_q   <= bte_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   // Storage is never cleared; reset only blocks the write.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_n_i && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
               mem_q[off_q[MEM_ADDR_W+1:2]][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = dat_q;

endmodule
